// File: rtl/dco_pkg.sv
// Shared constants and shift-request classification for the DCO phase stepper.
package dco_pkg;

  localparam int unsigned DCO_NOM_HALF = 50;
  localparam int unsigned DCO_STEP     = 4;
  localparam int unsigned DCO_MIN_HALF = 25;
  localparam int unsigned DCO_MAX_HALF = 100;

  typedef enum logic [1:0] {
    SHIFT_NONE = 2'd0,
    SHIFT_POS  = 2'd1,
    SHIFT_NEG  = 2'd2
  } shift_e;

  // Simultaneous positive and negative pulses cancel to SHIFT_NONE.
  function automatic shift_e classify_shift(input logic pos, input logic neg);
    if (pos && !neg) return SHIFT_POS;
    if (neg && !pos) return SHIFT_NEG;
    return SHIFT_NONE;
  endfunction

endpackage

// File: rtl/dco_trim_reg.sv
// Saturating up/down half-period trim register; used only when DCO_FREQ_TRACK_EN is defined.
module dco_trim_reg
  import dco_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned NOM_HALF = DCO_NOM_HALF,
  parameter int unsigned MIN_HALF = DCO_MIN_HALF,
  parameter int unsigned MAX_HALF = DCO_MAX_HALF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  shift_e           shift_i,
  output logic [CNT_W-1:0] trim_o
);

  localparam logic [CNT_W-1:0] NOM_W = CNT_W'(NOM_HALF);
  localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_HALF);
  localparam logic [CNT_W-1:0] ONE_W = CNT_W'(1);

  logic [CNT_W-1:0] trim_q, trim_d;

  // Advancing phase means the local oscillator is slow: shorten the half-period.
  always_comb begin
    trim_d = trim_q;
    case (shift_i)
      SHIFT_POS: if (trim_q > MIN_W) trim_d = trim_q - ONE_W;
      SHIFT_NEG: if (trim_q < MAX_W) trim_d = trim_q + ONE_W;
      default:   trim_d = trim_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) trim_q <= NOM_W;
    else         trim_q <= trim_d;
  end

  assign trim_o = trim_q;

endmodule

// File: rtl/dco_phase_stepper.sv
// DCO stage of the PLL: half-period counter with cycle skip/insert phase correction.
// Optional saturating frequency trim is enabled by defining DCO_FREQ_TRACK_EN.
module dco_phase_stepper
  import dco_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned NOM_HALF = DCO_NOM_HALF,
  parameter int unsigned STEP     = DCO_STEP,
  parameter int unsigned MIN_HALF = DCO_MIN_HALF,
  parameter int unsigned MAX_HALF = DCO_MAX_HALF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             positiveShift_i,
  input  logic             negativeShift_i,
  output logic             signal_o,
  output logic             edge_o,
  output logic [CNT_W-1:0] halfPeriod_o
);

  localparam logic [CNT_W-1:0] NOM_W  = CNT_W'(NOM_HALF);
  localparam logic [CNT_W-1:0] STEP_W = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] ONE_W  = CNT_W'(1);

  shift_e           shift;
  logic [CNT_W-1:0] trim;
  logic [CNT_W-1:0] inc;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic             sig_q, sig_d;
  logic             edge_q, edge_d;

  assign shift = classify_shift(positiveShift_i, negativeShift_i);

`ifdef DCO_FREQ_TRACK_EN
  dco_trim_reg #(
    .CNT_W    (CNT_W),
    .NOM_HALF (NOM_HALF),
    .MIN_HALF (MIN_HALF),
    .MAX_HALF (MAX_HALF)
  ) u_trim (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .shift_i (shift),
    .trim_o  (trim)
  );
`else
  assign trim = NOM_W;
`endif

  always_comb begin
    stall_d = stall_q;
    inc     = ONE_W;
    case (shift)
      SHIFT_POS: begin
        inc     = STEP_W + ONE_W;
        stall_d = '0;
      end
      // The pulse cycle itself is the first inserted cycle, hence STEP-1 remaining.
      SHIFT_NEG: begin
        inc     = '0;
        stall_d = STEP_W - ONE_W;
      end
      default: begin
        if (stall_q != '0) begin
          inc     = '0;
          stall_d = stall_q - ONE_W;
        end
      end
    endcase

    sum = {1'b0, cnt_q} + {1'b0, inc};
    // Overshoot past the boundary is dropped; at most one toggle per cycle.
    if (sum >= {1'b0, half_q}) begin
      cnt_d  = '0;
      sig_d  = ~sig_q;
      edge_d = ~sig_q;
      half_d = trim;
    end else begin
      cnt_d  = cnt_q + inc;
      sig_d  = sig_q;
      edge_d = 1'b0;
      half_d = half_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      stall_q <= '0;
      half_q  <= NOM_W;
      sig_q   <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      half_q  <= half_d;
      sig_q   <= sig_d;
      edge_q  <= edge_d;
    end
  end

  assign signal_o     = sig_q;
  assign edge_o       = edge_q;
  assign halfPeriod_o = half_q;

endmodule

// File: tb/tb_dco_phase_stepper.sv
// Scoreboard bench for dco_phase_stepper: directed scenarios plus randomized pulses/resets.
module tb_dco_phase_stepper;

  localparam int CNT_W = 16;
  localparam int NOM   = 50;
  localparam int STEP  = 4;
  localparam int MINH  = 25;
  localparam int MAXH  = 100;
`ifdef DCO_FREQ_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_i = 1'b1;
  logic             pos_i = 1'b0;
  logic             neg_i = 1'b0;
  logic             signal_o;
  logic             edge_o;
  logic [CNT_W-1:0] halfPeriod_o;

  dco_phase_stepper #(
    .CNT_W    (CNT_W),
    .NOM_HALF (NOM),
    .STEP     (STEP),
    .MIN_HALF (MINH),
    .MAX_HALF (MAXH)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .positiveShift_i (pos_i),
    .negativeShift_i (neg_i),
    .signal_o        (signal_o),
    .edge_o          (edge_o),
    .halfPeriod_o    (halfPeriod_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned tag;
    logic        sig;
    logic        edg;
    int          half;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_m;
  int unsigned tog_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          prev_sig = 1'b0;

  // Reference model: the oscillator state as the rules describe it.
  int mcnt = 0, mstall = 0, mhalf = NOM, mtrim = NOM;
  bit msig = 1'b0, medge = 1'b0;

  function automatic void model_step(input bit r, input bit p, input bit n);
    int  advance;
    int  new_trim;
    if (r) begin
      mcnt = 0; mstall = 0; mhalf = NOM; mtrim = NOM; msig = 1'b0; medge = 1'b0;
      return;
    end
    new_trim = mtrim;
    if (p && !n) begin
      advance = 1 + STEP; mstall = 0;
      if (TRACK && mtrim > MINH) new_trim = mtrim - 1;
    end else if (n && !p) begin
      advance = 0; mstall = STEP - 1;
      if (TRACK && mtrim < MAXH) new_trim = mtrim + 1;
    end else if (mstall > 0) begin
      advance = 0; mstall = mstall - 1;
    end else begin
      advance = 1;
    end
    if (mcnt + advance >= mhalf) begin
      msig = !msig; medge = msig; mcnt = 0; mhalf = mtrim;
    end else begin
      mcnt = mcnt + advance; medge = 1'b0;
    end
    mtrim = new_trim;
  endfunction

  // Monitor: the DUT presents a result every cycle; pop the matching expectation.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].tag < cyc) begin
      checks++; errors++;
      $display("FAIL stale_expect tag=%0d cyc=%0d", exp_q[0].tag, cyc);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
      e_m = exp_q.pop_front();
      checks++;
      if (signal_o !== e_m.sig || edge_o !== e_m.edg || halfPeriod_o !== CNT_W'(e_m.half)) begin
        errors++;
        $display("FAIL outputs cyc=%0d got sig=%b edge=%b half=%0d want sig=%b edge=%b half=%0d",
                 cyc, signal_o, edge_o, halfPeriod_o, e_m.sig, e_m.edg, e_m.half);
      end
    end
    if ((signal_o === 1'b1 && !prev_sig) || (signal_o === 1'b0 && prev_sig))
      tog_q.push_back(cyc);
    prev_sig = (signal_o === 1'b1);
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic cycle(input bit r, input bit p, input bit n);
    exp_t e;
    reset_i = r; pos_i = p; neg_i = n;
    model_step(r, p, n);
    e.tag = cyc + 1; e.sig = msig; e.edg = medge; e.half = mhalf;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    tog_q.delete();
  endtask

  task automatic idle_until_toggles(input int n);
    int guard = 0;
    while (tog_q.size() < n && guard < 400) begin
      cycle(1'b0, 1'b0, 1'b0);
      guard++;
    end
    if (tog_q.size() < n) begin
      checks++; errors++;
      $display("FAIL toggle_timeout got=%0d want=%0d", tog_q.size(), n);
    end
  endtask

  task automatic wait_cnt(input int target);
    int guard = 0;
    while ((mcnt != target || mstall != 0) && guard < 200) begin
      cycle(1'b0, 1'b0, 1'b0);
      guard++;
    end
  endtask

  // Half-period between toggles idx-1 and idx.
  task automatic check_half(input string name, input int idx, input int want);
    if (tog_q.size() <= idx) begin
      checks++; errors++;
      $display("FAIL %s got=missing want=%0d", name, want);
    end else begin
      check(name, int'(tog_q[idx] - tog_q[idx-1]), want);
    end
  endtask

  initial begin
    int unsigned rel;

    // Free-running after reset.
    do_reset();
    check("reset_signal", int'(signal_o), 0);
    check("reset_half", int'(halfPeriod_o), NOM);
    rel = cyc;
    idle_until_toggles(3);
    if (tog_q.size() >= 3) begin
      check("first_rise", int'(tog_q[0] - rel), NOM);
      check("edge_gap", int'(tog_q[2] - tog_q[0]), 2 * NOM);
    end
    check_half("free_half", 1, NOM);
    check("free_halfPeriod", int'(halfPeriod_o), NOM);

    // Positive pulse at cnt=10.
    do_reset(); idle_until_toggles(1);
    wait_cnt(10); cycle(1'b0, 1'b1, 1'b0);
    idle_until_toggles(3);
    check_half("pos_at_10", 1, NOM - STEP);
    check_half("after_pos", 2, TRACK ? NOM - 1 : NOM);

    // Single negative pulse at cnt=10.
    do_reset(); idle_until_toggles(1);
    wait_cnt(10); cycle(1'b0, 1'b0, 1'b1);
    idle_until_toggles(2);
    check_half("neg_at_10", 1, NOM + STEP);

    // Second negative two cycles later reloads the stall rather than adding to it.
    do_reset(); idle_until_toggles(1);
    wait_cnt(10);
    cycle(1'b0, 1'b0, 1'b1); cycle(1'b0, 1'b0, 1'b0); cycle(1'b0, 1'b0, 1'b1);
    idle_until_toggles(2);
    check_half("neg_reload", 1, NOM + STEP + 2);

    // Positive pulse one short of the boundary: single toggle, no carry.
    do_reset(); idle_until_toggles(1);
    wait_cnt(NOM - 2); cycle(1'b0, 1'b1, 1'b0);
    idle_until_toggles(3);
    check_half("pos_at_48", 1, NOM - 1);
    check_half("after_pos_48", 2, NOM);

    // Simultaneous pulses are ignored.
    do_reset(); idle_until_toggles(1);
    wait_cnt(20); cycle(1'b0, 1'b1, 1'b1);
    idle_until_toggles(2);
    check_half("both_pulses", 1, NOM);

`ifdef DCO_FREQ_TRACK_EN
    do_reset(); idle_until_toggles(1);
    wait_cnt(5);
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    check("trim_pending", int'(halfPeriod_o), NOM);
    idle_until_toggles(2);
    check("trim_applied", int'(halfPeriod_o), NOM - 3);
    repeat (30) cycle(1'b0, 1'b1, 1'b0);
    idle_until_toggles(tog_q.size() + 2);
    check("trim_saturated", int'(halfPeriod_o), MINH);
`endif

    // Reset asserted mid-period.
    idle_until_toggles(tog_q.size() + 1);
    repeat (20) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check("midreset_half", int'(halfPeriod_o), NOM);
    check("midreset_signal", int'(signal_o), 0);

    // Randomized pulses and occasional resets against the model.
    repeat (4000) begin
      cycle($urandom_range(0, 999) < 3, $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 4);
    end
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
